// File: rtl/galaga_shot_arbiter.sv
// Fire-button arbiter for the two-player shot path into the game FSM.
// One shot in flight at a time; a shot resolves against mp after its flight
// time and emits a one-cycle hit pulse for its owner.
// Optional build macro: GALAGA_SHOT_QUEUE_EN adds a one-deep pending request
// per player, captured while another player's shot is in flight.
module galaga_shot_arbiter #(
    parameter int unsigned TICK_DIV       = 16,
    parameter int unsigned FLIGHT_TICKS   = 4,
    parameter int unsigned COOLDOWN_TICKS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fire1,
    input  logic fire2,
    input  logic mp,
    input  logic done,
    output logic shot1,
    output logic shot2,
    output logic busy,
    output logic owner,
    output logic ready1,
    output logic ready2
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned FW = $clog2(FLIGHT_TICKS + 1);
    localparam int unsigned CW = $clog2(COOLDOWN_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FLIGHT  = 2'd1,
        S_RESOLVE = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [CW-1:0] ccnt1_q, ccnt1_d, ccnt2_q, ccnt2_d;
    logic          fire1_q, fire2_q;
    logic          last_q, last_d;          // 1 = P2 received the last grant
    logic          owner_q, owner_d;
    logic          busy_q, busy_d;
    logic          shot1_q, shot1_d, shot2_q, shot2_d;
    logic          ready1_q, ready1_d, ready2_q, ready2_d;
    logic          pend1_q, pend1_d, pend2_q, pend2_d;

    logic tick_c, req1_c, req2_c, cand1_c, cand2_c, elig1_c, elig2_c, grant2_c;

    // Prescaler, button edge detect and eligibility.
    always_comb begin
        tick_c  = (pre_q == PW'(TICK_DIV - 1));
        pre_d   = tick_c ? '0 : pre_q + PW'(1);
        req1_c  = fire1 & ~fire1_q;
        req2_c  = fire2 & ~fire2_q;
`ifdef GALAGA_SHOT_QUEUE_EN
        cand1_c = req1_c | pend1_q;
        cand2_c = req2_c | pend2_q;
`else
        cand1_c = req1_c;
        cand2_c = req2_c;
`endif
        elig1_c  = cand1_c & (ccnt1_q == '0);
        elig2_c  = cand2_c & (ccnt2_q == '0);
        // On a tie the player who did not win last time gets the shot.
        grant2_c = elig2_c & (~elig1_c | ~last_q);
    end

    // Shot FSM next-state, counters and registered outputs.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        shot1_d = 1'b0;
        shot2_d = 1'b0;
        pend1_d = pend1_q;
        pend2_d = pend2_q;
        ccnt1_d = (tick_c && ccnt1_q != '0) ? ccnt1_q - CW'(1) : ccnt1_q;
        ccnt2_d = (tick_c && ccnt2_q != '0) ? ccnt2_q - CW'(1) : ccnt2_q;

        case (state_q)
            S_IDLE: begin
                if (elig1_c || elig2_c) begin
                    state_d = S_FLIGHT;
                    owner_d = grant2_c;
                    last_d  = grant2_c;
                    fcnt_d  = FW'(FLIGHT_TICKS);
                    if (grant2_c) pend2_d = 1'b0;
                    else          pend1_d = 1'b0;
                end
            end
            S_FLIGHT: begin
                if (tick_c) begin
                    fcnt_d = fcnt_q - FW'(1);
                    // mp is captured here so the hit pulse lines up with RESOLVE.
                    if (fcnt_q == FW'(1)) begin
                        state_d = S_RESOLVE;
                        shot1_d = ~owner_q & mp;
                        shot2_d = owner_q & mp;
                    end
                end
            end
            S_RESOLVE: begin
                state_d = S_IDLE;
                if (owner_q) ccnt2_d = CW'(COOLDOWN_TICKS);
                else         ccnt1_d = CW'(COOLDOWN_TICKS);
            end
            default: state_d = S_HALT;
        endcase

        if (state_q == S_FLIGHT || state_q == S_RESOLVE) begin
            if (req1_c && owner_q)  pend1_d = 1'b1;
            if (req2_c && !owner_q) pend2_d = 1'b1;
        end

        // Game over freezes the arbiter until reset.
        if (done || state_q == S_HALT) begin
            state_d = S_HALT;
            shot1_d = 1'b0;
            shot2_d = 1'b0;
            pend1_d = 1'b0;
            pend2_d = 1'b0;
        end

`ifndef GALAGA_SHOT_QUEUE_EN
        pend1_d = 1'b0;
        pend2_d = 1'b0;
`endif

        busy_d   = (state_d == S_FLIGHT) || (state_d == S_RESOLVE);
        ready1_d = (ccnt1_d == '0);
        ready2_d = (ccnt2_d == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            fcnt_q   <= '0;
            ccnt1_q  <= '0;
            ccnt2_q  <= '0;
            fire1_q  <= 1'b0;
            fire2_q  <= 1'b0;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            busy_q   <= 1'b0;
            shot1_q  <= 1'b0;
            shot2_q  <= 1'b0;
            ready1_q <= 1'b1;
            ready2_q <= 1'b1;
            pend1_q  <= 1'b0;
            pend2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            fcnt_q   <= fcnt_d;
            ccnt1_q  <= ccnt1_d;
            ccnt2_q  <= ccnt2_d;
            fire1_q  <= fire1;
            fire2_q  <= fire2;
            last_q   <= last_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            shot1_q  <= shot1_d;
            shot2_q  <= shot2_d;
            ready1_q <= ready1_d;
            ready2_q <= ready2_d;
            pend1_q  <= pend1_d;
            pend2_q  <= pend2_d;
        end
    end

    assign shot1  = shot1_q;
    assign shot2  = shot2_q;
    assign busy   = busy_q;
    assign owner  = owner_q;
    assign ready1 = ready1_q;
    assign ready2 = ready2_q;

endmodule

// File: tb/tb_galaga_shot_arbiter.sv
// Directed bench for galaga_shot_arbiter with TICK_DIV=4, FLIGHT_TICKS=2,
// COOLDOWN_TICKS=8. Row r after reset release sees a tick when r % 4 == 3.
module tb_galaga_shot_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fire1 = 1'b0, fire2 = 1'b0, mp = 1'b0, done = 1'b0;
    logic shot1, shot2, busy, owner, ready1, ready2;

    int n_checks = 0;
    int n_errors = 0;

    galaga_shot_arbiter #(
        .TICK_DIV(4), .FLIGHT_TICKS(2), .COOLDOWN_TICKS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fire1(fire1), .fire2(fire2), .mp(mp),
        .done(done), .shot1(shot1), .shot2(shot2), .busy(busy), .owner(owner),
        .ready1(ready1), .ready2(ready2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   n;
        logic f1, f2, m;
        logic s1, s2, b, o, r1, r2;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic f1, input logic f2, input logic m, input logic d);
        fire1 = f1; fire2 = f2; mp = m; done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " shot1"}, int'(shot1), 0);
        chk({tag, " shot2"}, int'(shot2), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " owner"}, int'(owner), 0);
        chk({tag, " ready1"}, int'(ready1), 1);
        chk({tag, " ready2"}, int'(ready2), 1);
    endtask

    task automatic do_reset(input string tag);
        fire1 = 1'b0; fire2 = 1'b0; mp = 1'b0; done = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int c1, c2, bad;

        // Single P1 shot, cooldown window with ignored press, then tie after P1 -> P2.
        vecs[0] = '{1,  1, 0, 1,  0, 0, 1, 0, 1, 1};   // row 0: grant P1
        vecs[1] = '{6,  1, 0, 1,  0, 0, 1, 0, 1, 1};   // rows 1-6 in flight
        vecs[2] = '{1,  1, 0, 1,  1, 0, 1, 0, 1, 1};   // row 7: hit pulse
        vecs[3] = '{1,  1, 0, 1,  0, 0, 0, 0, 0, 1};   // row 8: cooldown loaded
        vecs[4] = '{3,  0, 0, 0,  0, 0, 0, 0, 0, 1};
        vecs[5] = '{2,  1, 0, 0,  0, 0, 0, 0, 0, 1};   // press during cooldown
        vecs[6] = '{25, 0, 0, 0,  0, 0, 0, 0, 0, 1};   // rows 14-38
        vecs[7] = '{1,  0, 0, 0,  0, 0, 0, 0, 1, 1};   // row 39: 8th tick
        vecs[8] = '{1,  1, 1, 0,  0, 0, 1, 1, 1, 1};   // row 40: tie -> P2
        vecs[9] = '{7,  0, 0, 0,  0, 0, 1, 1, 1, 1};   // rows 41-47, mp=0

        do_reset("reset0");
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                step(vecs[i].f1, vecs[i].f2, vecs[i].m, 1'b0);
                chk($sformatf("vec%0d.%0d shot1", i, k), int'(shot1), int'(vecs[i].s1));
                chk($sformatf("vec%0d.%0d shot2", i, k), int'(shot2), int'(vecs[i].s2));
                chk($sformatf("vec%0d.%0d busy", i, k), int'(busy), int'(vecs[i].b));
                chk($sformatf("vec%0d.%0d owner", i, k), int'(owner), int'(vecs[i].o));
                chk($sformatf("vec%0d.%0d ready1", i, k), int'(ready1), int'(vecs[i].r1));
                chk($sformatf("vec%0d.%0d ready2", i, k), int'(ready2), int'(vecs[i].r2));
            end
        end
        step(0, 0, 0, 0);                               // row 48: P2 resolved, no pulse
        chk("p2 resolve busy", int'(busy), 0);
        chk("p2 resolve ready2", int'(ready2), 0);
        chk("p2 resolve shot2", int'(shot2), 0);

        // Tie straight after reset goes to P1; exactly one P1 pulse.
        do_reset("reset_tie");
        step(1, 1, 1, 0);
        chk("tie owner", int'(owner), 0);
        chk("tie busy", int'(busy), 1);
        c1 = 0; c2 = 0;
        for (int r = 1; r <= 8; r++) begin
            step(0, 0, 1, 0);
            if (r == 7) chk("tie shot1 at row7", int'(shot1), 1);
            c1 += int'(shot1); c2 += int'(shot2);
        end
        chk("tie shot1 count", c1, 1);
        chk("tie shot2 count", c2, 0);

        // FIRE2 edge during P1 flight.
        do_reset("reset_queue");
        step(1, 0, 1, 0);
        step(0, 1, 1, 0);
        for (int r = 2; r <= 8; r++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);                               // row 9
`ifdef GALAGA_SHOT_QUEUE_EN
        chk("queued p2 busy", int'(busy), 1);
        chk("queued p2 owner", int'(owner), 1);
`else
        chk("dropped p2 busy", int'(busy), 0);
        chk("dropped p2 owner", int'(owner), 0);
`endif

        // DONE mid-flight halts; nothing fires afterwards.
        do_reset("reset_halt");
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);                               // row 3
        chk("halt busy", int'(busy), 0);
        bad = 0;
        for (int r = 0; r < 24; r++) begin
            step(r % 3 == 0, r % 3 == 1, 1'b1, 1'b0);
            bad += int'(busy) + int'(shot1) + int'(shot2);
        end
        chk("halt frozen activity", bad, 0);
        do_reset("reset_after_halt");
        step(1, 0, 1, 0);
        chk("post halt grant busy", int'(busy), 1);

        // Held button gives one shot; reset mid-flight aborts silently.
        do_reset("reset_hold");
        c1 = 0; c2 = 0;
        for (int r = 0; r < 100; r++) begin
            step(1, 0, 1, 0);
            c1 += int'(shot1); c2 += int'(shot2);
        end
        chk("hold shot1 count", c1, 1);
        chk("hold shot2 count", c2, 0);
        chk("hold busy end", int'(busy), 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("regrant busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        fire1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int r = 0; r < 12; r++) begin
            step(0, 0, 1, 0);
            bad += int'(busy) + int'(shot1) + int'(shot2);
        end
        chk("aborted shot silent", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
